// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin owner of a shared 4:1 word mux, with burst limit and a one-entry registered output stage.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req[3:0]          requester i presents a valid word on data_i
//   data_0..data_3    requester words
//   gnt[3:0]          one-hot, combinational; requester advances its word on the next edge
//   sel[1:0]          current owner, drives the shared mux selector
//   out_data          registered accepted word
//   out_valid         out_data holds a word
//   out_ready         consumer takes out_data when out_valid && out_ready
//   out_src[1:0]      requester index that supplied out_data
//
// Build option: define RR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module rr_mux4_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [DATA_WIDTH-1:0] data_3,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_src
);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e                state_q;
    logic [1:0]            owner_q, ptr_q, out_src_q, pick_d;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] out_data_q, mux_d;
    logic                  out_valid_q, busy, space, accept, last, done;
    // Scan from ptr upward (mod 4); iterating downward lets the nearest set bit win.
    always_comb begin
        pick_d = ptr_q;
        for (int k = 3; k >= 0; k--)
            if (req[ptr_q + 2'(k)]) pick_d = ptr_q + 2'(k);
    end
    assign mux_d  = owner_q == 2'd0 ? data_0 :
                    owner_q == 2'd1 ? data_1 :
                    owner_q == 2'd2 ? data_2 : data_3;
    assign busy   = state_q == BUSY;
    assign space  = !out_valid_q || out_ready;
    assign accept = busy && req[owner_q] && space;
    assign last   = cnt_q + 4'd1 == 4'(MAX_BURST);
    assign done   = busy && (!req[owner_q] || (accept && last));
    assign gnt    = accept ? 4'b0001 << owner_q : 4'b0000;
    assign sel    = owner_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd0;
            cnt_q       <= 4'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 2'd0;
        end else begin
            if (!busy && |req) begin
                state_q <= BUSY;
                owner_q <= pick_d;
                cnt_q   <= 4'd0;
            end
            if (accept) cnt_q <= cnt_q + 4'd1;
            if (done) begin
                state_q <= IDLE;
`ifdef RR_ARB_FIXED_PRIO_EN
                ptr_q   <= 2'd0;
`else
                ptr_q   <= owner_q + 2'd1;
`endif
            end
            if (accept) begin
                out_data_q  <= mux_d;
                out_src_q   <= owner_q;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: scoreboard bench for rr_mux4_arbiter (MAX_BURST=4).
module tb_rr_mux4_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data_0, data_1, data_2, data_3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wcnt[4] = '{default: 0};
    int          exp_beat[4] = '{default: 0};
    logic [3:0]  gnt_seen = 4'd0;
    logic [17:0] exp_q[$];
    logic [3:0]  er_tab[10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    logic [3:0]  bp_tab[11] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};

    always #5 clk = ~clk;

    function automatic logic [15:0] word(int s, int b);
        return 16'(32'hA000 + s * 256 + b);
    endfunction

    assign data_0 = word(0, wcnt[0]);
    assign data_1 = word(1, wcnt[1]);
    assign data_2 = word(2, wcnt[2]);
    assign data_3 = word(3, wcnt[3]);

    rr_mux4_arbiter #(.DATA_WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int s);
        exp_q.push_back({2'(s), word(s, exp_beat[s])});
        exp_beat[s]++;
    endtask

    task automatic obs();
        logic [17:0] e;
        #1;
        gnt_seen = gnt;
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (out_valid && !out_ready) chk("stall_gnt", 32'(gnt), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk("out_word", {14'd0, out_src, out_data}, {14'd0, e});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (gnt_seen[i]) wcnt[i]++;
        gnt_seen = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        obs();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rr_gnt(int k);
        return (k == 0 || k % 5 == 0 || k > 21) ? 4'd0 : 4'(1 << (((k - 1) / 5) % 4));
    endfunction

    function automatic logic [3:0] pr_gnt(int k);
        if (k == 0 || k % 5 == 0 || k > 14) return 4'd0;
`ifdef RR_ARB_FIXED_PRIO_EN
        return 4'b0010;
`else
        return (((k - 1) / 5) % 2) != 0 ? 4'b1000 : 4'b0010;
`endif
    endfunction

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_src", 32'(out_src), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        // round-robin with all requesters active
        for (int b = 0; b < 4; b++) repeat (4) push(b);
        push(0);
        for (int k = 0; k <= 22; k++) begin
            req = k < 22 ? 4'b1111 : 4'b0000;
            obs();
            chk("rr_gnt", 32'(gnt), 32'(rr_gnt(k)));
            if (k > 0 && k < 22) chk("rr_sel", 32'(sel), 32'(((k - 1) / 5) % 4));
            tick();
        end
        // early release by requester 0
        do_reset();
        push(0); push(0);
        repeat (4) push(2);
        for (int k = 0; k <= 9; k++) begin
            req = k < 3 ? 4'b0101 : k < 9 ? 4'b0100 : 4'b0000;
            obs();
            chk("er_gnt", 32'(gnt), 32'(er_tab[k]));
`ifndef RR_ARB_FIXED_PRIO_EN
            if (k == 4) chk("er_ptr", 32'(dut.ptr_q), 32'd1);
`endif
            if (k == 5) chk("er_sel", 32'(sel), 32'd2);
            tick();
        end
        // backpressure, then drain and accept on the same cycle
        do_reset();
        repeat (4) push(0);
        for (int k = 0; k <= 10; k++) begin
            req       = k < 10 ? 4'b0001 : 4'b0000;
            out_ready = !(k >= 3 && k <= 7);
            obs();
            chk("bp_gnt", 32'(gnt), 32'(bp_tab[k]));
            if (k >= 3 && k <= 7) begin
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_data", 32'(out_data), 32'(exp_q[0][15:0]));
            end
            if (k == 9) chk("da_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        // requesters 1 and 3 competing
        do_reset();
`ifdef RR_ARB_FIXED_PRIO_EN
        repeat (12) push(1);
`else
        repeat (4) push(1);
        repeat (4) push(3);
        repeat (4) push(1);
`endif
        for (int k = 0; k <= 15; k++) begin
            req = k < 15 ? 4'b1010 : 4'b0000;
            obs();
            chk("pr_gnt", 32'(gnt), 32'(pr_gnt(k)));
            tick();
        end
        // reset in the middle of a burst discards the held word
        do_reset();
        req = 4'b1000;
        obs();
        tick();
        obs();
        chk("mb_gnt1", 32'(gnt), 32'h8);
        tick();
        rst_n = 1'b0;
        obs();
        chk("mb_valid", 32'(out_valid), 32'd0);
        chk("mb_gnt", 32'(gnt), 32'd0);
        exp_beat[3]++;
        tick();
        req   = 4'd0;
        rst_n = 1'b1;
        obs();
        chk("mb_after", 32'(out_valid), 32'd0);
        tick();
        chk("sb_final", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter and sequencer that shares one 4:1 16-bit word multiplexer among four requesters. It chooses an owner and drives the mux `sel`. It accepts that owner's words in bursts of up to `MAX_BURST` beats and presents the mux output through a one-entry registered valid/ready output stage. It sits between the four word sources and the single downstream consumer of the shared datapath.

## Interface
- `DATA_WIDTH`, 16: width of each requester word and of `out_data`.
- `MAX_BURST`, 4: beats one owner may transfer per grant before arbitration rotates. Range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: `req[i]` means requester i presents a valid word on `data_i`.
- `data_0`..`data_3` in `DATA_WIDTH`: requester words.
- `gnt` out 4: one-hot, combinational. `gnt[i]`=1 means requester i's word is accepted this cycle, and the requester must advance its word on the next edge.
- `sel` out 2: owner index, driven to the shared mux selector.
- `out_data` out `DATA_WIDTH`: registered accepted word.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `out_src` out 2: requester index that supplied `out_data`.

## Operation
- States: IDLE and BUSY.
- Registers: `owner` (2b), `ptr` (2b, highest-priority index), `cnt` (4b beat counter), output stage.
- IDLE:
  - If `req`≠0, the owner is the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - Load `owner` and clear `cnt`, then go to BUSY.
  - No `gnt` is asserted in IDLE.
- BUSY:
  - `space` = `!out_valid || out_ready`.
  - `accept` = `req[owner] && space`. `gnt[owner]`=`accept`.
  - On `accept`: `out_data`←`data_owner`, `out_src`←`owner`, `out_valid`←1, `cnt`++.
- Leaving BUSY: go to IDLE with `ptr`←`owner+1` (mod 4, wraps 3→0) when either condition holds:
  - `accept` occurs with `cnt+1==MAX_BURST`;
  - `req[owner]`=0.
- A stalled owner (`req[owner]`=1, `space`=0) keeps the grant. No timeout.
- Output stage:
  - Drain without a new accept clears `out_valid`.
  - Simultaneous drain and accept reloads the register and keeps `out_valid`=1.
- `sel` = `owner` in BUSY. In IDLE, `sel` holds its last value.
- Requests other than the owner's are ignored until return to IDLE.
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `sel`=0, `gnt`=0. Internally, state=IDLE, `ptr`=0, `cnt`=0.
- Reset mid-burst aborts immediately. The word in the output register is discarded and no `gnt` is asserted.

## Timing
- Arbitration latency: `req` seen in IDLE at edge N gives BUSY from edge N. The first `gnt` is possible in the following cycle.
- Throughput: 1 beat/cycle within a burst when `out_ready`=1.
- Per-burst overhead: 1 IDLE cycle.
- Accept to `out_valid`: 1 cycle.
- `gnt` depends combinationally on `req`, `out_ready` and registered state only. There is no path from `data_*`.
- Full burst at full throughput: `MAX_BURST` consecutive `gnt` cycles, then 1 IDLE cycle.

## Configuration
- `RR_ARB_FIXED_PRIO_EN`:
  - Defined: IDLE scan always starts at index 0, so requester 0 has highest priority and requester 3 lowest. `ptr` is not updated.
  - Undefined (default): round-robin as described.
- Burst limit and handshake are identical in both builds.

## Test plan
- Reset: drive `rst_n`=0 with `req`=4'b1111, then release. Required: `gnt`=0 and `out_valid`=0 while reset is low; the first owner is 0 with `sel`=0.
- Round-robin: hold `req`=4'b1111 with `out_ready`=1 and `MAX_BURST`=4. Required: `out_src` sequence 0,0,0,0,1,1,1,1,2,…,3,3 then 0. Exactly one `gnt` bit per beat, one gap cycle between bursts.
- Early release: `req`=4'b0101, requester 0 drops `req` after 2 beats. Required: 2 words from src 0, then the owner becomes 2 and `ptr` becomes 1.
- Backpressure: `out_ready`=0 for 5 cycles mid-burst. Required: `gnt`=0, `out_data` stable at the last word, `out_valid`=1. Resume with the same owner and no lost or duplicated words (check via data pattern `16'hA000+beat`).
- Simultaneous drain and accept: `out_ready`=1 on the same cycle as a new beat. Required: `out_valid` stays 1 and `out_data` updates to the next word.
- Fixed-priority build (`RR_ARB_FIXED_PRIO_EN` defined): `req`=4'b1010 held. Required: owner is always 1, and requester 3 never gets a grant while `req[1]`=1.
